// File: rtl/inputconditioner_multi.sv
// Multi-channel input conditioner: per-channel synchroniser, counter debounce,
// registered edge pulses and consumer-clearable sticky edge flags.
module inputconditioner_multi #(
  parameter int   CHANNELS     = 4,
  parameter int   SYNC_STAGES  = 2,
  parameter int   WAITTIME     = 3,
  parameter int   COUNTERWIDTH = 3,
  parameter logic INIT_VALUE   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] clear_pos,
  input  logic [CHANNELS-1:0] clear_neg,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] pos_flag,
  output logic [CHANNELS-1:0] neg_flag,
  output logic                any_edge
);

  localparam logic [COUNTERWIDTH-1:0] WAIT_CNT = COUNTERWIDTH'(WAITTIME);
  localparam logic [COUNTERWIDTH-1:0] CNT_ONE  = COUNTERWIDTH'(1);

  // sync_q[0] samples the pin; sync_q[SYNC_STAGES-1] is the synchronised level
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  sync;

  logic [COUNTERWIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNTERWIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]     cond_d;
  logic [CHANNELS-1:0]     pe_d;
  logic [CHANNELS-1:0]     ne_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {(SYNC_STAGES*CHANNELS){INIT_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisysignal};
    end
  end

  // Counter only advances while the channel is enabled and mismatched, so it
  // tops out at WAITTIME: reaching it commits the new level and restarts at 0.
  always_comb begin
    cond_d = conditioned;
    pe_d   = '0;
    ne_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (enable[i] && (sync[i] != conditioned[i])) begin
        if (cnt_q[i] == WAIT_CNT) begin
          cond_d[i] = sync[i];
          pe_d[i]   = sync[i];
          ne_d[i]   = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      conditioned  <= {CHANNELS{INIT_VALUE}};
      positiveedge <= '0;
      negativeedge <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      conditioned  <= cond_d;
      positiveedge <= pe_d;
      negativeedge <= ne_d;
    end
  end

  // Flags are set by the registered pulse, so a clear landing in the pulse
  // cycle loses to the set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_flag <= '0;
      neg_flag <= '0;
    end else begin
      pos_flag <= positiveedge | (pos_flag & ~clear_pos);
      neg_flag <= negativeedge | (neg_flag & ~clear_neg);
    end
  end

  assign any_edge = |(positiveedge | negativeedge);

endmodule
